// File: rtl/ibex_tlul_host_adapter.sv
// ibex_tlul_host_adapter
//
// Bridges one Ibex memory port (req/gnt/rvalid, instruction or data side) onto a TL-UL host
// A/D channel pair. The A channel is driven from a register stage to keep core-side timing
// short. Issued and expected source IDs are tracked so in-order D responses can be matched
// back to requests. D beats that do not match are flagged on a sticky error output.
//
// Parameters
//   MaxOutstanding  max granted requests awaiting a D response (1..8)
//   SourceWidth     width of a_source / d_source
//   SourceBase      first source ID; IDs SourceBase .. SourceBase+MaxOutstanding-1 are used
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   req_i/gnt_o              core request and same-cycle grant
//   we_i, be_i, addr_i,      core request attributes
//   wdata_i
//   rvalid_o, rdata_o, err_o registered core response, one per grant, in order
//   err_spurious_o           sticky: D beat with nothing outstanding, or source mismatch
//   tl_a_*                   TL-UL A channel (host side)
//   tl_d_*                   TL-UL D channel (host side); tl_d_ready is tied high
//
// Configuration
//   IBEX_TLUL_PARITY_EN      when defined, drives per-byte even parity of tl_a_data on
//                            tl_a_user_parity[3:0], registered with the A fields.

module ibex_tlul_host_adapter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned SourceWidth    = 8,
  parameter int unsigned SourceBase     = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,

  // Ibex core side
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic                   we_i,
  input  logic [3:0]             be_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            wdata_i,
  output logic                   rvalid_o,
  output logic [31:0]            rdata_o,
  output logic                   err_o,
  output logic                   err_spurious_o,

  // TL-UL A channel
  output logic                   tl_a_valid,
  input  logic                   tl_a_ready,
  output logic [2:0]             tl_a_opcode,
  output logic [2:0]             tl_a_param,
  output logic [1:0]             tl_a_size,
  output logic [SourceWidth-1:0] tl_a_source,
  output logic [31:0]            tl_a_address,
  output logic [3:0]             tl_a_mask,
  output logic [31:0]            tl_a_data,
  output logic                   tl_a_user_parity_en,
  output logic [7:0]             tl_a_user_parity,

  // TL-UL D channel
  input  logic                   tl_d_valid,
  output logic                   tl_d_ready,
  input  logic [2:0]             tl_d_opcode,
  input  logic [SourceWidth-1:0] tl_d_source,
  input  logic [31:0]            tl_d_data,
  input  logic                   tl_d_error,
  input  logic                   tl_d_corrupt
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  localparam logic [CntW-1:0]        CntMax   = CntW'(MaxOutstanding);
  localparam logic [SourceWidth-1:0] SrcFirst = SourceWidth'(SourceBase);
  localparam logic [SourceWidth-1:0] SrcLast  = SourceWidth'(SourceBase + MaxOutstanding - 1);

  // TL-UL A opcodes
  localparam logic [2:0] OpPutFullData    = 3'd0;
  localparam logic [2:0] OpPutPartialData = 3'd1;
  localparam logic [2:0] OpGet            = 3'd4;

  // A channel register stage
  logic                   a_valid_q,   a_valid_d;
  logic [2:0]             a_opcode_q,  a_opcode_d;
  logic [1:0]             a_size_q,    a_size_d;
  logic [SourceWidth-1:0] a_source_q,  a_source_d;
  logic [31:0]            a_address_q, a_address_d;
  logic [3:0]             a_mask_q,    a_mask_d;
  logic [31:0]            a_data_q,    a_data_d;

  // Transaction tracking
  logic [SourceWidth-1:0] src_q,     src_d;      // next source ID to issue
  logic [SourceWidth-1:0] exp_src_q, exp_src_d;  // source ID of the oldest outstanding request
  logic [CntW-1:0]        cnt_q,     cnt_d;      // granted requests not yet answered

  // Registered core response
  logic                   rvalid_q,   rvalid_d;
  logic [31:0]            rdata_q,    rdata_d;
  logic                   err_q,      err_d;
  logic                   spur_q,     spur_d;

  logic                   gnt;
  logic                   d_accept;
  logic                   d_drop;
  logic                   d_match;
  logic [31:0]            a_data_new;

  // The A register can take a new request when it is empty or is being drained this cycle.
  // The outstanding count already includes a request still sitting in the A register.
  assign gnt = req_i & (~a_valid_q | tl_a_ready) & (cnt_q < CntMax);

  // D beats are always accepted; only those with something outstanding become responses.
  assign d_accept = tl_d_valid & (cnt_q != '0);
  assign d_drop   = tl_d_valid & (cnt_q == '0);
  assign d_match  = (tl_d_source == exp_src_q);

  assign a_data_new = we_i ? wdata_i : 32'h0;

  always_comb begin
    a_valid_d   = a_valid_q;
    a_opcode_d  = a_opcode_q;
    a_size_d    = a_size_q;
    a_source_d  = a_source_q;
    a_address_d = a_address_q;
    a_mask_d    = a_mask_q;
    a_data_d    = a_data_q;
    src_d       = src_q;

    if (gnt) begin
      a_valid_d   = 1'b1;
      if (!we_i) begin
        a_opcode_d = OpGet;
      end else if (be_i == 4'hF) begin
        a_opcode_d = OpPutFullData;
      end else begin
        a_opcode_d = OpPutPartialData;
      end
      a_size_d    = 2'd2;
      a_source_d  = src_q;
      a_address_d = {addr_i[31:2], 2'b00};
      a_mask_d    = be_i;
      a_data_d    = a_data_new;
      src_d       = (src_q == SrcLast) ? SrcFirst : src_q + SourceWidth'(1);
    end else if (a_valid_q && tl_a_ready) begin
      // Fields are left as they were; only the valid flag matters once drained.
      a_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    exp_src_d = exp_src_q;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    spur_d    = spur_q;

    unique case ({gnt, d_accept})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (d_accept) begin
      // A mismatched source still retires the oldest request so the core never stalls
      // waiting for a response that the fabric has already consumed.
      rvalid_d  = 1'b1;
      rdata_d   = tl_d_data;
      err_d     = tl_d_error | tl_d_corrupt | ~d_match;
      exp_src_d = (exp_src_q == SrcLast) ? SrcFirst : exp_src_q + SourceWidth'(1);
      if (!d_match) begin
        spur_d = 1'b1;
      end
    end

    if (d_drop) begin
      spur_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_valid_q   <= 1'b0;
      a_opcode_q  <= 3'd0;
      a_size_q    <= 2'd0;
      a_source_q  <= '0;
      a_address_q <= 32'h0;
      a_mask_q    <= 4'h0;
      a_data_q    <= 32'h0;
      src_q       <= SrcFirst;
      exp_src_q   <= SrcFirst;
      cnt_q       <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      spur_q      <= 1'b0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_opcode_q  <= a_opcode_d;
      a_size_q    <= a_size_d;
      a_source_q  <= a_source_d;
      a_address_q <= a_address_d;
      a_mask_q    <= a_mask_d;
      a_data_q    <= a_data_d;
      src_q       <= src_d;
      exp_src_q   <= exp_src_d;
      cnt_q       <= cnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      spur_q      <= spur_d;
    end
  end

`ifdef IBEX_TLUL_PARITY_EN
  logic [7:0] parity_q, parity_d;

  // Even parity per byte of the data being loaded, so it stays aligned with tl_a_data.
  always_comb begin
    parity_d = parity_q;
    if (gnt) begin
      parity_d = {4'h0, ^a_data_new[31:24], ^a_data_new[23:16],
                  ^a_data_new[15:8], ^a_data_new[7:0]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      parity_q <= 8'h0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign tl_a_user_parity_en = 1'b1;
  assign tl_a_user_parity    = parity_q;
`else
  assign tl_a_user_parity_en = 1'b0;
  assign tl_a_user_parity    = 8'h0;
`endif

  assign gnt_o          = gnt;

  assign tl_a_valid     = a_valid_q;
  assign tl_a_opcode    = a_opcode_q;
  assign tl_a_param     = 3'd0;
  assign tl_a_size      = a_size_q;
  assign tl_a_source    = a_source_q;
  assign tl_a_address   = a_address_q;
  assign tl_a_mask      = a_mask_q;
  assign tl_a_data      = a_data_q;

  assign tl_d_ready     = 1'b1;

  assign rvalid_o       = rvalid_q;
  assign rdata_o        = rdata_q;
  assign err_o          = err_q;
  assign err_spurious_o = spur_q;

  // The D opcode carries nothing the core needs; the address LSBs are dropped on purpose.
  logic unused_inputs;
  assign unused_inputs = ^{tl_d_opcode, addr_i[1:0]};

endmodule

// File: tb/tb_ibex_tlul_host_adapter.sv
module tb_ibex_tlul_host_adapter;

  localparam int MaxOut = 2;

  logic        clk_i;
  logic        rst_i;
  logic        req_i, gnt_o, we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i;
  logic        rvalid_o, err_o, err_spurious_o;
  logic [31:0] rdata_o;
  logic        tl_a_valid, tl_a_ready;
  logic [2:0]  tl_a_opcode, tl_a_param;
  logic [1:0]  tl_a_size;
  logic [7:0]  tl_a_source;
  logic [31:0] tl_a_address, tl_a_data;
  logic [3:0]  tl_a_mask;
  logic        tl_a_user_parity_en;
  logic [7:0]  tl_a_user_parity;
  logic        tl_d_valid, tl_d_ready;
  logic [2:0]  tl_d_opcode;
  logic [7:0]  tl_d_source;
  logic [31:0] tl_d_data;
  logic        tl_d_error, tl_d_corrupt;

  ibex_tlul_host_adapter #(
    .MaxOutstanding(MaxOut),
    .SourceWidth   (8),
    .SourceBase    (0)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .req_i              (req_i),
    .gnt_o              (gnt_o),
    .we_i               (we_i),
    .be_i               (be_i),
    .addr_i             (addr_i),
    .wdata_i            (wdata_i),
    .rvalid_o           (rvalid_o),
    .rdata_o            (rdata_o),
    .err_o              (err_o),
    .err_spurious_o     (err_spurious_o),
    .tl_a_valid         (tl_a_valid),
    .tl_a_ready         (tl_a_ready),
    .tl_a_opcode        (tl_a_opcode),
    .tl_a_param         (tl_a_param),
    .tl_a_size          (tl_a_size),
    .tl_a_source        (tl_a_source),
    .tl_a_address       (tl_a_address),
    .tl_a_mask          (tl_a_mask),
    .tl_a_data          (tl_a_data),
    .tl_a_user_parity_en(tl_a_user_parity_en),
    .tl_a_user_parity   (tl_a_user_parity),
    .tl_d_valid         (tl_d_valid),
    .tl_d_ready         (tl_d_ready),
    .tl_d_opcode        (tl_d_opcode),
    .tl_d_source        (tl_d_source),
    .tl_d_data          (tl_d_data),
    .tl_d_error         (tl_d_error),
    .tl_d_corrupt       (tl_d_corrupt)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [7:0]  src;
  } a_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } r_exp_t;

  a_exp_t      a_q[$];
  r_exp_t      r_q[$];
  a_exp_t      ea;
  r_exp_t      er;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata;
  int          m_src, m_exp_src, m_cnt;
  logic [7:0]  exp_par;
  logic        exp_par_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A channel monitor: every cycle the A register is valid it must equal the oldest
  // expected beat; it is retired on handshake.
  always @(negedge clk_i) begin
    if (!rst_i && tl_a_valid) begin
      if (a_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_beat: unexpected A beat addr 0x%0h", tl_a_address);
      end else begin
        ea = a_q[0];
`ifdef IBEX_TLUL_PARITY_EN
        exp_par    = {4'h0, ^ea.data[31:24], ^ea.data[23:16], ^ea.data[15:8], ^ea.data[7:0]};
        exp_par_en = 1'b1;
`else
        exp_par    = 8'h0;
        exp_par_en = 1'b0;
`endif
        chk("a_opcode", 32'(tl_a_opcode), 32'(ea.op));
        chk("a_address", tl_a_address, ea.addr);
        chk("a_mask", 32'(tl_a_mask), 32'(ea.mask));
        chk("a_data", tl_a_data, ea.data);
        chk("a_source", 32'(tl_a_source), 32'(ea.src));
        chk("a_size", 32'(tl_a_size), 32'd2);
        chk("a_param", 32'(tl_a_param), 32'd0);
        chk("a_parity", 32'(tl_a_user_parity), 32'(exp_par));
        chk("a_parity_en", 32'(tl_a_user_parity_en), 32'(exp_par_en));
        if (tl_a_ready) void'(a_q.pop_front());
      end
    end
  end

  // Response monitor: each rvalid_o pops the oldest expected response; otherwise rdata_o holds.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (rvalid_o) begin
        if (r_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rvalid: unexpected response rdata 0x%0h", rdata_o);
        end else begin
          er = r_q.pop_front();
          chk("rdata", rdata_o, er.data);
          chk("err", 32'(err_o), 32'(er.err));
          last_rdata = er.data;
        end
      end else begin
        chk("rdata_hold", rdata_o, last_rdata);
      end
    end
  end

  // One clock of stimulus. Expected grant is hand-supplied; granted requests and accepted
  // D beats push their expected A beat / core response into the scoreboard queues.
  task automatic cyc(input logic req, input logic we, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wd, input logic ardy,
                     input logic dv, input logic [7:0] dsrc, input logic [31:0] dd,
                     input logic derr, input logic exp_gnt);
    a_exp_t na;
    r_exp_t nr;
    req_i = req; we_i = we; be_i = be; addr_i = addr; wdata_i = wd;
    tl_a_ready = ardy;
    tl_d_valid = dv; tl_d_source = dsrc; tl_d_data = dd; tl_d_error = derr;
    @(negedge clk_i);
    chk("gnt", 32'(gnt_o), 32'(exp_gnt));
    // D is judged against the count before this cycle's grant.
    if (dv && m_cnt > 0) begin
      nr.data = dd;
      nr.err  = derr | tl_d_corrupt | (32'(dsrc) != 32'(m_exp_src));
      r_q.push_back(nr);
      m_exp_src = (m_exp_src + 1) % MaxOut;
      m_cnt--;
    end
    if (exp_gnt) begin
      na.op   = !we ? 3'd4 : ((be == 4'hF) ? 3'd0 : 3'd1);
      na.addr = {addr[31:2], 2'b00};
      na.mask = be;
      na.data = we ? wd : 32'h0;
      na.src  = 8'(m_src);
      a_q.push_back(na);
      m_src = (m_src + 1) % MaxOut;
      m_cnt++;
    end
    @(posedge clk_i);
    #1;
    req_i = 1'b0; tl_d_valid = 1'b0; tl_d_error = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 8'h0, 32'h0, 0, 0);
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    req_i = 1'b0; tl_d_valid = 1'b0; tl_d_error = 1'b0; tl_d_corrupt = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    a_q.delete();
    r_q.delete();
    m_src = 0; m_exp_src = 0; m_cnt = 0;
    last_rdata = 32'h0;
  endtask

  initial begin
    req_i = 0; we_i = 0; be_i = 0; addr_i = 0; wdata_i = 0;
    tl_a_ready = 1; tl_d_valid = 0; tl_d_opcode = 3'd1; tl_d_source = 0;
    tl_d_data = 0; tl_d_error = 0; tl_d_corrupt = 0;
    reset_dut();

    // Reset state
    @(negedge clk_i);
    chk("rst_a_valid", 32'(tl_a_valid), 32'd0);
    chk("rst_a_opcode", 32'(tl_a_opcode), 32'd0);
    chk("rst_a_address", tl_a_address, 32'h0);
    chk("rst_a_mask", 32'(tl_a_mask), 32'd0);
    chk("rst_a_data", tl_a_data, 32'h0);
    chk("rst_a_source", 32'(tl_a_source), 32'd0);
    chk("rst_a_size", 32'(tl_a_size), 32'd0);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_spurious", 32'(err_spurious_o), 32'd0);
    chk("d_ready", 32'(tl_d_ready), 32'd1);
    @(posedge clk_i);
    #1;

    // Single read, D next cycle
    cyc(1, 0, 4'hF, 32'h1000_0006, 32'h0, 1, 0, 8'd0, 32'h0, 0, 1);
    cyc(0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 8'd0, 32'hDEAD_BEEF, 0, 0);
    idle(2);

    // Writes: partial, full (with D overlapping grants), D error
    cyc(1, 1, 4'h3, 32'h3000_0008, 32'h1234_5678, 1, 0, 8'd0, 32'h0, 0, 1);
    cyc(1, 1, 4'hF, 32'h3000_000C, 32'hCAFE_F00D, 1, 1, 8'd1, 32'h0000_0011, 0, 1);
    cyc(1, 1, 4'hF, 32'h3000_0010, 32'h0000_01FF, 1, 1, 8'd0, 32'h0000_0022, 1, 1);
    cyc(0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 8'd1, 32'h0000_0033, 0, 0);
    idle(2);
    chk("spurious_clean", 32'(err_spurious_o), 32'd0);

    // Backpressure: one grant while A is stalled, then the outstanding limit blocks a third
    cyc(1, 0, 4'hF, 32'h2000_0000, 32'h0, 0, 0, 8'd0, 32'h0, 0, 1);
    repeat (5) cyc(1, 0, 4'hF, 32'h2000_0010, 32'h0, 0, 0, 8'd0, 32'h0, 0, 0);
    cyc(1, 0, 4'hF, 32'h2000_0010, 32'h0, 1, 0, 8'd0, 32'h0, 0, 1);
    cyc(1, 0, 4'hF, 32'h2000_0020, 32'h0, 1, 0, 8'd0, 32'h0, 0, 0);
    cyc(1, 0, 4'hF, 32'h2000_0020, 32'h0, 1, 1, 8'd0, 32'h0000_0044, 0, 0);
    cyc(1, 0, 4'hF, 32'h2000_0020, 32'h0, 1, 0, 8'd0, 32'h0, 0, 1);
    cyc(0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 8'd1, 32'h0000_0055, 0, 0);
    cyc(0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 8'd0, 32'h0000_0066, 0, 0);
    idle(2);

    // Back-to-back reads from a fresh state; sources 0,1,0,1, one corrupt beat
    reset_dut();
    cyc(1, 0, 4'hF, 32'h4000_0000, 32'h0, 1, 0, 8'd0, 32'h0, 0, 1);
    cyc(1, 0, 4'hF, 32'h4000_0004, 32'h0, 1, 1, 8'd0, 32'h0000_00A0, 0, 1);
    cyc(1, 0, 4'hF, 32'h4000_0008, 32'h0, 1, 1, 8'd1, 32'h0000_00A1, 0, 1);
    tl_d_corrupt = 1'b1;
    cyc(1, 0, 4'hF, 32'h4000_000C, 32'h0, 1, 1, 8'd0, 32'h0000_00A2, 0, 1);
    tl_d_corrupt = 1'b0;
    cyc(0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 8'd1, 32'h0000_00A3, 0, 0);
    idle(2);

    // Count is back to zero: the next D beat is spurious and produces no response
    chk("spurious_before", 32'(err_spurious_o), 32'd0);
    cyc(0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 8'd0, 32'h0000_0BAD, 0, 0);
    @(negedge clk_i);
    chk("spurious_no_rvalid", 32'(rvalid_o), 32'd0);
    chk("spurious_set", 32'(err_spurious_o), 32'd1);
    @(posedge clk_i);
    #1;
    idle(3);
    chk("spurious_sticky", 32'(err_spurious_o), 32'd1);

    // Source mismatch still retires the request with err_o and sets the sticky flag
    reset_dut();
    chk("spurious_cleared", 32'(err_spurious_o), 32'd0);
    cyc(1, 0, 4'hF, 32'h5000_0000, 32'h0, 1, 0, 8'd0, 32'h0, 0, 1);
    cyc(0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 8'd1, 32'h0000_0077, 0, 0);
    @(negedge clk_i);
    chk("mismatch_rvalid", 32'(rvalid_o), 32'd1);
    chk("mismatch_spurious", 32'(err_spurious_o), 32'd1);
    @(posedge clk_i);
    #1;
    idle(1);

    // Reset with two requests outstanding
    reset_dut();
    cyc(1, 0, 4'hF, 32'h6000_0000, 32'h0, 1, 0, 8'd0, 32'h0, 0, 1);
    cyc(1, 0, 4'hF, 32'h6000_0004, 32'h0, 1, 0, 8'd0, 32'h0, 0, 1);
    reset_dut();
    @(negedge clk_i);
    chk("midrst_a_valid", 32'(tl_a_valid), 32'd0);
    chk("midrst_spurious", 32'(err_spurious_o), 32'd0);
    @(posedge clk_i);
    #1;
    // Late D beat from before reset arrives alongside a new request
    cyc(1, 0, 4'hF, 32'h6000_0008, 32'h0, 1, 1, 8'd1, 32'h0000_0088, 0, 1);
    @(negedge clk_i);
    chk("late_d_no_rvalid", 32'(rvalid_o), 32'd0);
    chk("late_d_spurious", 32'(err_spurious_o), 32'd1);
    @(posedge clk_i);
    #1;
    cyc(0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 8'd0, 32'h0000_0099, 0, 0);
    idle(2);

    chk("a_queue_empty", 32'(a_q.size()), 32'd0);
    chk("r_queue_empty", 32'(r_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
